// File: rtl/decode_wb_1.sv
// -----------------------------------------------------------------------------
// decode_wb_1 : Y86-64 decode / write-back stage
//
// Purpose
//   Consumes the D pipeline register, picks source/destination register IDs,
//   reads the 15-entry register file, and resolves data hazards by forwarding
//   from E, M and W. It also performs W-stage write-back and drives the
//   E pipeline register, which can be loaded with a bubble.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   D_*                      D pipeline register (stat, icode, ifun, rA, rB,
//                            valC, valP)
//   e_dstE, e_valE           execute-stage forwarding source
//   M_dstE, M_dstM, M_valE,
//   m_valM                   memory-stage forwarding sources
//   W_dstE, W_dstM, W_valE,
//   W_valM                   write-back port and last forwarding source
//   E_bubble                 load a nop into E on the next edge
//   d_srcA, d_srcB           combinational source IDs for the hazard unit
//   E_*                      E pipeline register outputs
// -----------------------------------------------------------------------------
module decode_wb_1 #(
    parameter logic [3:0] RNONE = 4'hF,
    parameter logic [3:0] RRSP  = 4'h4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  D_stat,
    input  logic [3:0]  D_icode,
    input  logic [3:0]  D_ifun,
    input  logic [3:0]  D_rA,
    input  logic [3:0]  D_rB,
    input  logic [63:0] D_valC,
    input  logic [63:0] D_valP,
    input  logic [3:0]  e_dstE,
    input  logic [63:0] e_valE,
    input  logic [3:0]  M_dstE,
    input  logic [3:0]  M_dstM,
    input  logic [63:0] M_valE,
    input  logic [63:0] m_valM,
    input  logic [3:0]  W_dstE,
    input  logic [3:0]  W_dstM,
    input  logic [63:0] W_valE,
    input  logic [63:0] W_valM,
    input  logic        E_bubble,
    output logic [3:0]  d_srcA,
    output logic [3:0]  d_srcB,
    output logic [1:0]  E_stat,
    output logic [3:0]  E_icode,
    output logic [3:0]  E_ifun,
    output logic [63:0] E_valC,
    output logic [63:0] E_valA,
    output logic [63:0] E_valB,
    output logic [3:0]  E_dstE,
    output logic [3:0]  E_dstM,
    output logic [3:0]  E_srcA,
    output logic [3:0]  E_srcB
);

    localparam int NREGS = 15;

    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    logic [63:0] rf_q [0:NREGS-1];

    logic [3:0]  d_srcA_s;
    logic [3:0]  d_srcB_s;
    logic [3:0]  d_dstE_s;
    logic [3:0]  d_dstM_s;
    logic [63:0] rf_a_s;
    logic [63:0] rf_b_s;
    logic [63:0] d_valA_s;
    logic [63:0] d_valB_s;

    logic [1:0]  e_stat_d,  e_stat_q;
    logic [3:0]  e_icode_d, e_icode_q;
    logic [3:0]  e_ifun_d,  e_ifun_q;
    logic [63:0] e_valC_d,  e_valC_q;
    logic [63:0] e_valA_d,  e_valA_q;
    logic [63:0] e_valB_d,  e_valB_q;
    logic [3:0]  e_dstE_d,  e_dstE_q;
    logic [3:0]  e_dstM_d,  e_dstM_q;
    logic [3:0]  e_srcA_d,  e_srcA_q;
    logic [3:0]  e_srcB_d,  e_srcB_q;

    // Forwarding chain: the youngest producer wins. A source of RNONE never
    // matches, so a "no register" destination can not leak data into it.
    function automatic logic [63:0] fwd_sel(
        input logic [3:0]  src,
        input logic [63:0] rf_val,
        input logic [3:0]  f_e_dstE,
        input logic [63:0] f_e_valE,
        input logic [3:0]  f_M_dstM,
        input logic [63:0] f_m_valM,
        input logic [3:0]  f_M_dstE,
        input logic [63:0] f_M_valE,
        input logic [3:0]  f_W_dstM,
        input logic [63:0] f_W_valM,
        input logic [3:0]  f_W_dstE,
        input logic [63:0] f_W_valE
    );
        logic [63:0] r;
        if (src == RNONE)           r = rf_val;
        else if (src == f_e_dstE)   r = f_e_valE;
        else if (src == f_M_dstM)   r = f_m_valM;
        else if (src == f_M_dstE)   r = f_M_valE;
        else if (src == f_W_dstM)   r = f_W_valM;
        else if (src == f_W_dstE)   r = f_W_valE;
        else                        r = rf_val;
        return r;
    endfunction

    // Register ID selection from the instruction code.
    always_comb begin
        d_srcA_s = RNONE;
        d_srcB_s = RNONE;
        d_dstE_s = RNONE;
        d_dstM_s = RNONE;
        case (D_icode)
            I_RRMOVQ: begin
                d_srcA_s = D_rA;
                d_dstE_s = D_rB;
            end
            I_IRMOVQ: d_dstE_s = D_rB;
            I_RMMOVQ: begin
                d_srcA_s = D_rA;
                d_srcB_s = D_rB;
            end
            I_MRMOVQ: begin
                d_srcB_s = D_rB;
                d_dstM_s = D_rA;
            end
            I_OPQ: begin
                d_srcA_s = D_rA;
                d_srcB_s = D_rB;
                d_dstE_s = D_rB;
            end
            I_CALL: begin
                d_srcB_s = RRSP;
                d_dstE_s = RRSP;
            end
            I_RET: begin
                d_srcA_s = RRSP;
                d_srcB_s = RRSP;
                d_dstE_s = RRSP;
            end
            I_PUSHQ: begin
                d_srcA_s = D_rA;
                d_srcB_s = RRSP;
                d_dstE_s = RRSP;
            end
            I_POPQ: begin
                d_srcA_s = RRSP;
                d_srcB_s = RRSP;
                d_dstE_s = RRSP;
                d_dstM_s = D_rA;
            end
            default: begin
                d_srcA_s = RNONE;
                d_srcB_s = RNONE;
                d_dstE_s = RNONE;
                d_dstM_s = RNONE;
            end
        endcase
    end

    // Asynchronous register-file read; RNONE reads as zero.
    always_comb begin
        rf_a_s = 64'd0;
        rf_b_s = 64'd0;
        if (d_srcA_s != RNONE) rf_a_s = rf_q[d_srcA_s];
        else                   rf_a_s = 64'd0;
        if (d_srcB_s != RNONE) rf_b_s = rf_q[d_srcB_s];
        else                   rf_b_s = 64'd0;
    end

    // Operand selection: jXX/call carry valP in valA, else forward or read.
    always_comb begin
        d_valA_s = 64'd0;
        d_valB_s = fwd_sel(d_srcB_s, rf_b_s, e_dstE, e_valE, M_dstM, m_valM,
                           M_dstE, M_valE, W_dstM, W_valM, W_dstE, W_valE);
        if ((D_icode == I_JXX) || (D_icode == I_CALL)) begin
            d_valA_s = D_valP;
        end else begin
            d_valA_s = fwd_sel(d_srcA_s, rf_a_s, e_dstE, e_valE, M_dstM, m_valM,
                               M_dstE, M_valE, W_dstM, W_valM, W_dstE, W_valE);
        end
    end

    // Register-file write-back; valM is tested first so popq %rsp keeps
    // the loaded value when both ports name the same register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) rf_q[i] <= 64'd0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if ((W_dstM != RNONE) && (W_dstM == 4'(i)))      rf_q[i] <= W_valM;
                else if ((W_dstE != RNONE) && (W_dstE == 4'(i))) rf_q[i] <= W_valE;
                else                                             rf_q[i] <= rf_q[i];
            end
        end
    end

    // E register next state: bubble on reset or request, else capture decode.
    always_comb begin
        e_stat_d  = 2'd0;
        e_icode_d = I_NOP;
        e_ifun_d  = 4'd0;
        e_valC_d  = 64'd0;
        e_valA_d  = 64'd0;
        e_valB_d  = 64'd0;
        e_dstE_d  = RNONE;
        e_dstM_d  = RNONE;
        e_srcA_d  = RNONE;
        e_srcB_d  = RNONE;
        if (rst || E_bubble) begin
            e_icode_d = I_NOP;
        end else begin
            e_stat_d  = D_stat;
            e_icode_d = D_icode;
            e_ifun_d  = D_ifun;
            e_valC_d  = D_valC;
            e_valA_d  = d_valA_s;
            e_valB_d  = d_valB_s;
            e_dstE_d  = d_dstE_s;
            e_dstM_d  = d_dstM_s;
            e_srcA_d  = d_srcA_s;
            e_srcB_d  = d_srcB_s;
        end
    end

    // E pipeline register.
    always_ff @(posedge clk) begin
        e_stat_q  <= e_stat_d;
        e_icode_q <= e_icode_d;
        e_ifun_q  <= e_ifun_d;
        e_valC_q  <= e_valC_d;
        e_valA_q  <= e_valA_d;
        e_valB_q  <= e_valB_d;
        e_dstE_q  <= e_dstE_d;
        e_dstM_q  <= e_dstM_d;
        e_srcA_q  <= e_srcA_d;
        e_srcB_q  <= e_srcB_d;
    end

    assign d_srcA  = d_srcA_s;
    assign d_srcB  = d_srcB_s;
    assign E_stat  = e_stat_q;
    assign E_icode = e_icode_q;
    assign E_ifun  = e_ifun_q;
    assign E_valC  = e_valC_q;
    assign E_valA  = e_valA_q;
    assign E_valB  = e_valB_q;
    assign E_dstE  = e_dstE_q;
    assign E_dstM  = e_dstM_q;
    assign E_srcA  = e_srcA_q;
    assign E_srcB  = e_srcB_q;

endmodule
